// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and read-port select values.
package hilo_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative datapath shared by multiply (shift-add) and divide (restoring
// shift-subtract); one step per cycle while i_step is high, operating on magnitudes.
module hilo_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_next;

  // Multiply: acc = {partial, multiplier}, add multiplicand on lsb, shift right.
  // Divide: acc = {remainder, dividend/quotient}, shift left, keep diff on no borrow.
  always_comb begin
    w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff      = w_rem_shift - {1'b0, r_opnd};
    w_acc_next  = {w_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_diff[WIDTH]) begin
        w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
      end else begin
        w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_is_div <= i_is_div;
      r_opnd   <= i_is_div ? i_b : i_a;
      r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
    end else if (i_step) begin
      r_acc <= w_acc_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle mult/multu/div/divu unit owning HI/LO with a start/busy/done handshake.
// Signed op support is enabled by defining SIGNED_MULDIV_EN.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_stall
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_state_next;
  logic [CW-1:0]      r_count;
  logic               r_is_div;
  logic               r_signed;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_b_zero;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_signed_in;
  logic               w_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_hi_next;
  logic [WIDTH-1:0]   w_lo_next;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SIGNED_MULDIV_EN
  assign w_signed_in = op[0];
`else
  // op[0] has no effect in the unsigned-only build
  assign w_signed_in = op[0] & 1'b0;
`endif

  assign w_mag_a = (w_signed_in && a[WIDTH-1]) ? -a : a;
  assign w_mag_b = (w_signed_in && b[WIDTH-1]) ? -b : b;

  hilo_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_step   (r_state == S_RUN),
    .i_is_div (op[1]),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_acc    (w_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_count == '0) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sign correction applied once on the magnitude result in FIX.
  always_comb begin
    w_neg     = r_signed & (r_sign_a ^ r_sign_b);
    w_q       = w_acc[WIDTH-1:0];
    w_r       = w_acc[2*WIDTH-1:WIDTH];
    w_prod    = w_neg ? -w_acc : w_acc;
    w_hi_next = w_prod[2*WIDTH-1:WIDTH];
    w_lo_next = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_lo_next = (r_signed && r_sign_a) ? WIDTH'(1) : '1;
        w_hi_next = r_a;
      end else begin
        w_lo_next = w_neg ? -w_q : w_q;
        w_hi_next = (r_signed && r_sign_a) ? -w_r : w_r;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_signed   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_b_zero   <= 1'b0;
      r_div_zero <= 1'b0;
      r_a        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      if (w_accept) begin
        r_count    <= CW'(WIDTH - 1);
        r_is_div   <= op[1];
        r_signed   <= w_signed_in;
        r_sign_a   <= a[WIDTH-1];
        r_sign_b   <= b[WIDTH-1];
        r_b_zero   <= (b == '0);
        r_a        <= a;
        r_div_zero <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_count <= r_count - CW'(1);
      end
      if (r_state == S_FIX) begin
        r_hi       <= w_hi_next;
        r_lo       <= w_lo_next;
        r_div_zero <= r_is_div & r_b_zero;
      end
    end
  end

  assign busy     = (r_state == S_RUN) || (r_state == S_FIX);
  assign done     = (r_state == S_DONE);
  assign div_zero = r_div_zero;
  assign rd_stall = rd_en & busy;
  assign rd_data  = (rd_sel == RD_HI) ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit; expected values are hand-computed
// and follow SIGNED_MULDIV_EN when the bench is built with it.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         rd_en;
  logic         rd_sel;
  logic [W-1:0] rd_data;
  logic         rd_stall;

  int n_vec = 0;
  int n_err = 0;

  hilo_muldiv_unit #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_stall (rd_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges counted from the start edge until done is seen; bounded.
  task automatic wait_done(output int edges, output int bcyc);
    edges = 0;
    bcyc  = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) bcyc++;
      tick();
      edges++;
    end
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    rd_sel = RD_LO;
    #1 lo = rd_data;
    rd_sel = RD_HI;
    #1 hi = rd_data;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int edges, bcyc;
    logic [W-1:0] hi, lo;
    issue(o, x, y);
    wait_done(edges, bcyc);
    chk({tag, " latency"}, edges, 33);
    read_hilo(hi, lo);
    chk({tag, " HI"}, hi, exp_hi);
    chk({tag, " LO"}, lo, exp_lo);
    tick();
    chk({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    int edges, bcyc;
    logic [W-1:0] hi, lo;

    rst = 1'b1; start = 1'b0; op = OP_MULTU; a = '0; b = '0; rd_en = 1'b0; rd_sel = RD_LO;
    #1;
    rd_en = 1'b1;
    read_hilo(hi, lo);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset div_zero", div_zero, 0);
    chk("reset rd_stall", rd_stall, 0);
    chk("reset HI", hi, 0);
    chk("reset LO", lo, 0);
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // multu max*max with busy window and latency
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(edges, bcyc);
    chk("multu latency", edges, 33);
    chk("multu busy cycles", bcyc, 33);
    chk("multu busy in done", busy, 0);
    read_hilo(hi, lo);
    chk("multu HI", hi, 32'hFFFF_FFFE);
    chk("multu LO", lo, 32'h0000_0001);
    tick();

`ifdef SIGNED_MULDIV_EN
    run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div -16/0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'h0000_0001);
    run_op("div 7/0", OP_DIV, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`else
    run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div -16/0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div 7/0", OP_DIV, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
`endif

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // divide by zero flag set, then cleared by the next accepted start
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(edges, bcyc);
    chk("divu 5/0 latency", edges, 33);
    read_hilo(hi, lo);
    chk("divu 5/0 HI", hi, 32'd5);
    chk("divu 5/0 LO", lo, 32'hFFFF_FFFF);
    chk("divu 5/0 div_zero", div_zero, 1);
    tick();
    chk("div_zero held", div_zero, 1);
    issue(OP_MULTU, 32'd2, 32'd3);
    chk("div_zero cleared on start", div_zero, 0);
    wait_done(edges, bcyc);
    read_hilo(hi, lo);
    chk("multu 2*3 HI", hi, 32'd0);
    chk("multu 2*3 LO", lo, 32'd6);
    chk("multu 2*3 div_zero", div_zero, 0);
    tick();

    // read stall while busy, and a mid-run start that must be ignored
    issue(OP_MULTU, 32'h1234_5678, 32'h0000_0010);
    repeat (3) tick();
    rd_en  = 1'b1;
    rd_sel = RD_HI;
    #1 chk("rd_stall while busy", rd_stall, 1);
    rd_en = 1'b0;
    issue(OP_DIVU, 32'd1, 32'd1);
    wait_done(edges, bcyc);
    chk("ignored start latency", edges, 29);
    rd_en = 1'b1;
    read_hilo(hi, lo);
    chk("rd_stall when done", rd_stall, 0);
    chk("ignored start HI", hi, 32'h0000_0001);
    chk("ignored start LO", lo, 32'h2345_6780);
    rd_en = 1'b0;
    tick();

    // back-to-back: start accepted in the DONE cycle, no gap
    issue(OP_MULTU, 32'd7, 32'd9);
    wait_done(edges, bcyc);
    read_hilo(hi, lo);
    chk("b2b first LO in done cycle", lo, 32'd63);
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy after done", busy, 1);
    wait_done(edges, bcyc);
    chk("b2b second latency", edges, 33);
    read_hilo(hi, lo);
    chk("b2b second HI", hi, 32'd2);
    chk("b2b second LO", lo, 32'd14);
    tick();

    // asynchronous reset in the middle of a divide
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("mid-run rst busy", busy, 0);
    chk("mid-run rst done", done, 0);
    chk("mid-run rst div_zero", div_zero, 0);
    read_hilo(hi, lo);
    chk("mid-run rst HI", hi, 32'd0);
    chk("mid-run rst LO", lo, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post-rst idle done", done, 0);
    run_op("post-rst divu 1000/3", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
